// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader: FSM state encoding and default widths.
package operand_loader_pkg;

  localparam int DEF_WIDTH = 2;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [2:0] {
    LD_A = 3'd0,
    LD_B = 3'd1,
    LD_C = 3'd2,
    LD_D = 3'd3,
    HOLD = 3'd4
  } state_t;

endpackage

// File: rtl/operand_loader.sv
// Assembles a serial stream of words (a, b, c, d) into one registered operand
// frame and presents it downstream with a valid/ready handshake.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy
);

  state_t state, state_nxt;
  logic   accept, consume;
  logic   load_a, load_b, load_c, load_d;

  // Handshake flags decode from registered state only; no path from op_ready to in_ready.
  assign in_ready = (state != HOLD);
  assign op_valid = (state == HOLD);
  assign busy     = (state == LD_B) || (state == LD_C) || (state == LD_D);
  assign accept   = in_valid && in_ready && !flush;
  assign consume  = op_valid && op_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LD_A;
    else        state <= state_nxt;
  end

  // flush wins over an offered word while loading; HOLD ignores it.
  always_comb begin
    state_nxt = state;
    load_a    = 1'b0;
    load_b    = 1'b0;
    load_c    = 1'b0;
    load_d    = 1'b0;
    case (state)
      LD_A: begin
        if (flush)       state_nxt = LD_A;
        else if (accept) begin load_a = 1'b1; state_nxt = LD_B; end
      end
      LD_B: begin
        if (flush)       state_nxt = LD_A;
        else if (accept) begin load_b = 1'b1; state_nxt = LD_C; end
      end
      LD_C: begin
        if (flush)       state_nxt = LD_A;
        else if (accept) begin load_c = 1'b1; state_nxt = LD_D; end
      end
      LD_D: begin
        if (flush)       state_nxt = LD_A;
        else if (accept) begin load_d = 1'b1; state_nxt = HOLD; end
      end
      HOLD: begin
        if (op_ready) state_nxt = LD_A;
      end
      default: state_nxt = LD_A;
    endcase
  end

  // Operands change only on their own accept, so they stay stable through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      c <= '0;
      d <= '0;
    end else begin
      if (load_a) a <= in_data;
      if (load_b) b <= in_data;
      if (load_c) c <= in_data;
      if (load_d) d <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       frame_cnt <= '0;
    else if (consume) frame_cnt <= frame_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_operand_loader.sv
// Directed self-checking bench for operand_loader; a second instance with a
// 2-bit frame counter shares the stimulus to exercise counter wrap.
module tb_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_data;
  logic       flush;
  logic       op_ready;

  logic       in_ready, op_valid, busy;
  logic [1:0] a, b, c, d;
  logic [7:0] frame_cnt;

  logic       in_ready2, op_valid2, busy2;
  logic [1:0] a2, b2, c2, d2;
  logic [1:0] frame_cnt2;

  int checks = 0;
  int errors = 0;
  int out;

  operand_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .a(a), .b(b), .c(c), .d(d),
    .op_valid(op_valid), .op_ready(op_ready), .frame_cnt(frame_cnt), .busy(busy)
  );

  operand_loader #(.WIDTH(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .flush(flush), .a(a2), .b(b2), .c(c2), .d(d2),
    .op_valid(op_valid2), .op_ready(op_ready), .frame_cnt(frame_cnt2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({op_valid, busy, in_ready} !== 3'b001) begin
      errors++; $display("FAIL reset_flags: got %b expected 001", {op_valid, busy, in_ready});
    end
    checks++;
    if ({a, b, c, d} !== 8'h00 || frame_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_regs: got ops=%h cnt=%0d expected ops=00 cnt=0", {a, b, c, d}, frame_cnt);
    end
    checks++;
    if ({op_valid2, busy2, in_ready2} !== 3'b001 || frame_cnt2 !== 2'd0) begin
      errors++; $display("FAIL reset_dut2: got flags=%b cnt=%0d expected 001 0", {op_valid2, busy2, in_ready2}, frame_cnt2);
    end
  endtask

  task automatic test_basic();
    op_ready = 1'b1;
    send(2'd1);
    checks++;
    if ({busy, op_valid} !== 2'b10) begin
      errors++; $display("FAIL basic_busy: got busy,op_valid=%b expected 10", {busy, op_valid});
    end
    send(2'd2);
    send(2'd1);
    checks++;
    if (op_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid: got %b expected 0", op_valid);
    end
    send(2'd3);
    checks++;
    if ({op_valid, in_ready, busy} !== 3'b100 || {a, b, c, d} !== 8'h67) begin
      errors++; $display("FAIL basic_frame: got flags=%b ops=%h expected 100 67", {op_valid, in_ready, busy}, {a, b, c, d});
    end
    out = ((int'(a) + int'(b)) * int'(d) - int'(c)) & 15;
    checks++;
    if (out !== 8) begin
      errors++; $display("FAIL basic_out: got %0d expected 8", out);
    end
    step();
    checks++;
    if (op_valid !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== 8'd1 || frame_cnt2 !== 2'd1) begin
      errors++; $display("FAIL basic_consume: got op_valid=%b in_ready=%b cnt=%0d cnt2=%0d expected 0 1 1 1", op_valid, in_ready, frame_cnt, frame_cnt2);
    end
  endtask

  task automatic test_backpressure();
    op_ready = 1'b0;
    send(2'd3); send(2'd3); send(2'd0); send(2'd3);
    in_valid = 1'b1;
    in_data  = 2'd2;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({op_valid, in_ready} !== 2'b10 || {a, b, c, d} !== 8'hF3) begin
        errors++; $display("FAIL bp_hold cycle %0d: got flags=%b ops=%h expected 10 f3", i, {op_valid, in_ready}, {a, b, c, d});
      end
      step();
    end
    out = ((int'(a) + int'(b)) * int'(d) - int'(c)) & 15;
    checks++;
    if (out !== 2) begin
      errors++; $display("FAIL bp_out: got %0d expected 2", out);
    end
    op_ready = 1'b1;
    step();
    checks++;
    if (op_valid !== 1'b0 || frame_cnt !== 8'd2 || frame_cnt2 !== 2'd2 || a !== 2'd3) begin
      errors++; $display("FAIL bp_consume: got op_valid=%b cnt=%0d cnt2=%0d a=%0d expected 0 2 2 3", op_valid, frame_cnt, frame_cnt2, a);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (a !== 2'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL bp_held_word: got a=%0d busy=%b expected 2 1", a, busy);
    end
    send(2'd0); send(2'd0); send(2'd0);
    checks++;
    if (op_valid !== 1'b1 || {a, b, c, d} !== 8'h80) begin
      errors++; $display("FAIL bp_next_frame: got op_valid=%b ops=%h expected 1 80", op_valid, {a, b, c, d});
    end
    step();
    checks++;
    if (frame_cnt !== 8'd3 || frame_cnt2 !== 2'd3) begin
      errors++; $display("FAIL bp_cnt: got %0d/%0d expected 3/3", frame_cnt, frame_cnt2);
    end
  endtask

  task automatic test_gapped();
    logic [1:0] words [4];
    words = '{2'd2, 2'd1, 2'd3, 2'd0};
    op_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send(words[k]);
      if (k < 3) begin
        checks++;
        if ({busy, op_valid} !== 2'b10) begin
          errors++; $display("FAIL gap_accept %0d: got busy,op_valid=%b expected 10", k, {busy, op_valid});
        end
        for (int g = 0; g < 2; g++) begin
          step();
          checks++;
          if ({busy, op_valid} !== 2'b10) begin
            errors++; $display("FAIL gap_idle %0d/%0d: got busy,op_valid=%b expected 10", k, g, {busy, op_valid});
          end
        end
      end else begin
        checks++;
        if ({busy, op_valid} !== 2'b01 || {a, b, c, d} !== 8'h9C) begin
          errors++; $display("FAIL gap_frame: got flags=%b ops=%h expected 01 9c", {busy, op_valid}, {a, b, c, d});
        end
      end
    end
    out = ((int'(a) + int'(b)) * int'(d) - int'(c)) & 15;
    checks++;
    if (out !== 13) begin
      errors++; $display("FAIL gap_out: got %0d expected 13", out);
    end
    op_ready = 1'b1;
    step();
    checks++;
    if (frame_cnt !== 8'd4 || frame_cnt2 !== 2'd0) begin
      errors++; $display("FAIL gap_cnt: got %0d/%0d expected 4/0", frame_cnt, frame_cnt2);
    end
  endtask

  task automatic test_flush();
    op_ready = 1'b0;
    send(2'd1); send(2'd1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 2'd2;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({busy, in_ready, op_valid} !== 3'b010 || {a, b, c, d} !== 8'h5C || frame_cnt !== 8'd4) begin
      errors++; $display("FAIL flush_abort: got flags=%b ops=%h cnt=%0d expected 010 5c 4", {busy, in_ready, op_valid}, {a, b, c, d}, frame_cnt);
    end
    send(2'd0); send(2'd1); send(2'd2); send(2'd3);
    checks++;
    if (op_valid !== 1'b1 || {a, b, c, d} !== 8'h1B) begin
      errors++; $display("FAIL flush_reload: got op_valid=%b ops=%h expected 1 1b", op_valid, {a, b, c, d});
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (op_valid !== 1'b1 || {a, b, c, d} !== 8'h1B) begin
      errors++; $display("FAIL flush_in_hold: got op_valid=%b ops=%h expected 1 1b", op_valid, {a, b, c, d});
    end
    op_ready = 1'b1;
    step();
    checks++;
    if (frame_cnt !== 8'd5 || frame_cnt2 !== 2'd1) begin
      errors++; $display("FAIL flush_cnt: got %0d/%0d expected 5/1", frame_cnt, frame_cnt2);
    end
  endtask

  task automatic test_async_reset();
    op_ready = 1'b0;
    send(2'd2); send(2'd2); send(2'd2); send(2'd2);
    checks++;
    if (op_valid !== 1'b1) begin
      errors++; $display("FAIL areset_pre: got op_valid=%b expected 1", op_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({op_valid, busy} !== 2'b00 || {a, b, c, d} !== 8'h00 || frame_cnt !== 8'd0 || frame_cnt2 !== 2'd0) begin
      errors++; $display("FAIL areset_now: got flags=%b ops=%h cnt=%0d/%0d expected 00 00 0/0", {op_valid, busy}, {a, b, c, d}, frame_cnt, frame_cnt2);
    end
    #1 rst_n = 1'b1;
    step();
    op_ready = 1'b1;
    send(2'd1); send(2'd0); send(2'd0); send(2'd1);
    checks++;
    if (op_valid !== 1'b1 || {a, b, c, d} !== 8'h41) begin
      errors++; $display("FAIL areset_reload: got op_valid=%b ops=%h expected 1 41", op_valid, {a, b, c, d});
    end
    step();
    checks++;
    if (frame_cnt !== 8'd1 || frame_cnt2 !== 2'd1) begin
      errors++; $display("FAIL areset_cnt: got %0d/%0d expected 1/1", frame_cnt, frame_cnt2);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] w;
    logic [1:0] exp2 [5];
    exp2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    op_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w = 2'(i);
      send(w); send(w + 2'd1); send(w + 2'd2); send(w + 2'd3);
      checks++;
      if (op_valid2 !== 1'b1 || {a2, b2, c2, d2} !== {w, w + 2'd1, w + 2'd2, w + 2'd3}) begin
        errors++; $display("FAIL wrap_frame %0d: got op_valid2=%b ops=%h", i, op_valid2, {a2, b2, c2, d2});
      end
      step();
      checks++;
      if (frame_cnt2 !== exp2[i] || frame_cnt !== 8'(i + 1)) begin
        errors++; $display("FAIL wrap_cnt %0d: got %0d/%0d expected %0d/%0d", i, frame_cnt, frame_cnt2, i + 1, exp2[i]);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 2'd0;
    flush    = 1'b0;
    op_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_flush();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
